// File: rtl/rtcsplit_recorder.sv
// Split recorder for the BCD stopwatch: digit-serial BCD lap subtraction feeding a
// lap FIFO that the CPU drains through a Wishbone slave port.
module rtcsplit_recorder #(
  parameter int unsigned LGDEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [30:0] i_value,
  input  logic        i_running,
  input  logic        i_split,
  input  logic        i_sw_clear,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic        i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_int
);

  localparam int unsigned DEPTH = 1 << LGDEPTH;
  localparam int unsigned PW    = LGDEPTH + 1;
  localparam logic [30:0] DIGIT_MASK = 31'h7F7F_7FFF;

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_PUSH} state_t;

  state_t              state_q, state_d;
  logic [2:0]          d_q, d_d;
  logic                borrow_q, borrow_d;
  logic [31:0]         cur_q, cur_d;
  logic [31:0]         prev_q, prev_d;
  logic [31:0]         lap_q, lap_d;
  logic                clr_pend_q, clr_pend_d;
  logic                ovf_q, ovf_d;
  logic                missed_q, missed_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                int_q, int_d;
  logic [30:0]         mem_q [DEPTH];

  logic                wb_req, wr_ctrl, flush, clr_flags, zero_prev;
  logic                pop, push, push_ok, empty, full;
  logic [PW-1:0]       fill;
  logic [3:0]          cur_dig, prev_dig;
  logic [4:0]          diff, radix;
  logic                unused_c;

  function automatic logic [4:0] radix_of(input logic [2:0] d);
    case (d)
      3'd3, 3'd5: radix_of = 5'd6;
      3'd7:       radix_of = 5'd8;
      default:    radix_of = 5'd10;
    endcase
  endfunction

  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_int      = int_q;
  assign unused_c   = &{1'b0, i_wb_data[31:2], lap_q[31]};

  // Bus decode and FIFO occupancy
  assign wb_req    = i_wb_cyc & i_wb_stb;
  assign wr_ctrl   = wb_req & i_wb_we & ~i_wb_addr;
  assign flush     = wr_ctrl & i_wb_data[1];
  assign clr_flags = wr_ctrl & i_wb_data[0];
  assign zero_prev = i_sw_clear | flush;
  assign fill      = wr_ptr_q - rd_ptr_q;
  assign empty     = (fill == '0);
  assign full      = (fill == PW'(DEPTH));
  assign pop       = wb_req & ~i_wb_we & i_wb_addr & ~empty;

  assign cur_dig  = cur_q[{d_q, 2'b00} +: 4];
  assign prev_dig = prev_q[{d_q, 2'b00} +: 4];
  assign radix    = radix_of(d_q);
  assign diff     = {1'b0, cur_dig} - {1'b0, prev_dig} - 5'(borrow_q);

  // Lap FSM and status flags
  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    borrow_d   = borrow_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    lap_d      = lap_q;
    clr_pend_d = clr_pend_q;
    ovf_d      = ovf_q;
    missed_d   = missed_q;
    push       = 1'b0;

    if (clr_flags) begin
      ovf_d    = 1'b0;
      missed_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (zero_prev) prev_d = '0;
        if (i_split) begin
          cur_d      = {1'b0, i_value & DIGIT_MASK};
          d_d        = 3'd0;
          borrow_d   = 1'b0;
          lap_d      = '0;
          clr_pend_d = 1'b0;
          state_d    = S_SUB;
        end
      end
      S_SUB: begin
        if (zero_prev) clr_pend_d = 1'b1;
        if (i_split) missed_d = 1'b1;
        if (diff[4]) begin
          lap_d[{d_q, 2'b00} +: 4] = 4'(diff + radix);
          borrow_d = 1'b1;
        end else begin
          lap_d[{d_q, 2'b00} +: 4] = diff[3:0];
          borrow_d = 1'b0;
        end
        d_d = d_q + 3'd1;
        if (d_q == 3'd7) state_d = S_PUSH;
      end
      S_PUSH: begin
        if (i_split) missed_d = 1'b1;
        push    = ~flush;
        prev_d  = (clr_pend_q | zero_prev) ? '0 : cur_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A same-cycle pop frees a slot before the push is judged
    push_ok = push & (~full | pop);
    if (push & full & ~pop) ovf_d = 1'b1;
  end

  // FIFO pointers and registered bus response
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ack_d    = wb_req;
    rdata_d  = '0;
    int_d    = ~empty;

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (wb_req && !i_wb_we) begin
      if (i_wb_addr) begin
        if (!empty) rdata_d = {1'b1, mem_q[rd_ptr_q[LGDEPTH-1:0]]};
      end else begin
        rdata_d = {ovf_q, missed_q, i_running, 21'b0, 8'(fill)};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      d_q        <= '0;
      borrow_q   <= 1'b0;
      cur_q      <= '0;
      prev_q     <= '0;
      lap_q      <= '0;
      clr_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      missed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      borrow_q   <= borrow_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      lap_q      <= lap_d;
      clr_pend_q <= clr_pend_d;
      ovf_q      <= ovf_d;
      missed_q   <= missed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      int_q      <= int_d;
    end
  end

  // Lap storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (!i_reset && push_ok) mem_q[wr_ptr_q[LGDEPTH-1:0]] <= lap_q[30:0];
  end

endmodule

// File: tb/tb_rtcsplit_recorder.sv
// Bench for rtcsplit_recorder: scenario tasks checked against a centisecond-arithmetic
// model of lap durations and a queue model of the lap FIFO.
module tb_rtcsplit_recorder;
  localparam int unsigned LGD   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TOTAL = 28800000;

  logic        i_clk, i_reset, i_running, i_split, i_sw_clear;
  logic        i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr;
  logic [30:0] i_value;
  logic [31:0] i_wb_data;
  logic        o_wb_stall, o_wb_ack, o_int;
  logic [31:0] o_wb_data;

  int vectors = 0;
  int miscompares = 0;

  logic [30:0] m_q [$];
  logic [30:0] m_prev;
  bit          m_ovf, m_missed;

  rtcsplit_recorder #(.LGDEPTH(LGD)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_value(i_value), .i_running(i_running),
    .i_split(i_split), .i_sw_clear(i_sw_clear), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data), .o_int(o_int)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int unsigned to_cs(input logic [30:0] v);
    int unsigned h, m, s, c;
    h = v[30:28] * 10 + v[27:24];
    m = v[22:20] * 10 + v[19:16];
    s = v[14:12] * 10 + v[11:8];
    c = v[7:4] * 10 + v[3:0];
    return ((h * 60 + m) * 60 + s) * 100 + c;
  endfunction

  function automatic logic [30:0] from_cs(input int unsigned cs);
    int unsigned h, m, s, c;
    c = cs % 100;
    s = (cs / 100) % 60;
    m = (cs / 6000) % 60;
    h = (cs / 360000) % 80;
    return {3'(h / 10), 4'(h % 10), 1'b0, 3'(m / 10), 4'(m % 10), 1'b0,
            3'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [30:0] lap_of(input logic [30:0] cur, input logic [30:0] prev);
    return from_cs((to_cs(cur) + TOTAL - to_cs(prev)) % TOTAL);
  endfunction

  function automatic logic [30:0] rand_bcd();
    return from_cs($urandom_range(TOTAL - 1, 0));
  endfunction

  function automatic logic [31:0] status_exp();
    return {m_ovf, m_missed, i_running, 21'b0, 8'(m_q.size())};
  endfunction

  function automatic logic [31:0] pop_exp();
    if (m_q.size() == 0) return 32'h0;
    return {1'b1, m_q.pop_front()};
  endfunction

  task automatic model_push(input logic [30:0] lap);
    if (m_q.size() < DEPTH) m_q.push_back(lap);
    else m_ovf = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc(2);
    i_reset = 1'b0;
    m_q.delete();
    m_prev = '0;
    m_ovf = 1'b0;
    m_missed = 1'b0;
  endtask

  task automatic wb_read(input logic addr, output logic ack, output logic [31:0] data);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = addr;
    cyc(1);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    ack = o_wb_ack;
    data = o_wb_data;
  endtask

  task automatic wb_write(input logic addr, input logic [31:0] wdata, output logic ack);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = addr; i_wb_data = wdata;
    cyc(1);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    ack = o_wb_ack;
  endtask

  task automatic do_split(input logic [30:0] v, input logic clr);
    i_value = v; i_split = 1'b1; i_sw_clear = clr;
    cyc(1);
    i_split = 1'b0; i_sw_clear = 1'b0;
    cyc(10);
    if (clr) m_prev = '0;
    model_push(lap_of(v, m_prev));
    m_prev = v;
  endtask

  task automatic test_reset();
    logic ack;
    logic [31:0] d;
    do_reset();
    vectors++;
    if ({o_wb_ack, o_int, o_wb_data} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got ack=%b int=%b data=%h required 0,0,0", o_wb_ack, o_int, o_wb_data);
    end
    wb_read(1'b0, ack, d);
    vectors++;
    if (ack !== 1'b1 || d !== status_exp()) begin
      miscompares++;
      $display("FAIL reset_status got ack=%b %h required 1 %h", ack, d, status_exp());
    end
    cyc(1);
    vectors++;
    if (o_wb_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_single got %b required 0", o_wb_ack);
    end
  endtask

  task automatic test_basic();
    logic ack;
    logic [31:0] d;
    logic [31:0] req [2] = '{32'h8001_2345, 32'h8000_4665};
    do_reset();
    do_split(31'h0001_2345, 1'b0);
    do_split(31'h0002_1010, 1'b0);
    vectors++;
    if (o_int !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_int got %b required 1", o_int);
    end
    for (int i = 0; i < 2; i++) begin
      wb_read(1'b1, ack, d);
      vectors++;
      if (d !== req[i] || d !== pop_exp()) begin
        miscompares++;
        $display("FAIL basic_lap%0d got %h required %h", i, d, req[i]);
      end
    end
  endtask

  task automatic test_borrow_chain();
    logic ack;
    logic [31:0] d, e;
    do_reset();
    cyc(8);
    do_split(31'h0, 1'b0);
    do_split(31'h0059_5999, 1'b0);
    do_split(31'h0100_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wb_read(1'b1, ack, d);
      e = pop_exp();
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL borrow_lap%0d got %h required %h", i, d, e);
      end
    end
    vectors++;
    if (e !== 32'h8000_0001 || d !== 32'h8000_0001) begin
      miscompares++;
      $display("FAIL borrow_chain got %h required 80000001", d);
    end
  endtask

  task automatic test_missed();
    logic ack;
    logic [31:0] d, e;
    do_reset();
    i_value = 31'h0000_1200; i_split = 1'b1;
    cyc(1);
    i_split = 1'b0;
    cyc(2);
    i_value = 31'h0000_1300; i_split = 1'b1;
    cyc(1);
    i_split = 1'b0;
    cyc(10);
    model_push(lap_of(31'h0000_1200, m_prev));
    m_prev = 31'h0000_1200;
    m_missed = 1'b1;
    wb_read(1'b0, ack, d);
    vectors++;
    if (d !== status_exp() || d[30] !== 1'b1) begin
      miscompares++;
      $display("FAIL missed_status got %h required %h", d, status_exp());
    end
    wb_write(1'b0, 32'h1, ack);
    m_missed = 1'b0;
    m_ovf = 1'b0;
    wb_read(1'b0, ack, d);
    vectors++;
    if (d !== status_exp() || d[31:29] !== 3'b000) begin
      miscompares++;
      $display("FAIL missed_clear got %h required %h", d, status_exp());
    end
    wb_read(1'b1, ack, d);
    e = pop_exp();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL missed_lap got %h required %h", d, e);
    end
  endtask

  task automatic test_overflow();
    logic ack;
    logic [31:0] d, e;
    logic [30:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) do_split(rand_bcd(), 1'b0);
    wb_read(1'b0, ack, d);
    vectors++;
    if (d !== status_exp() || d[7:0] !== 8'd4 || d[31] !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_status got %h required %h", d, status_exp());
    end
    for (int i = 0; i < 4; i++) begin
      wb_read(1'b1, ack, d);
      e = pop_exp();
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL ovf_lap%0d got %h required %h", i, d, e);
      end
    end
    wb_write(1'b0, 32'h1, ack);
    m_ovf = 1'b0;
    m_missed = 1'b0;
    for (int i = 0; i < 4; i++) do_split(rand_bcd(), 1'b0);
    // Pop lands on the PUSH cycle of the next lap
    v = rand_bcd();
    i_value = v; i_split = 1'b1;
    cyc(1);
    i_split = 1'b0;
    cyc(8);
    wb_read(1'b1, ack, d);
    e = pop_exp();
    model_push(lap_of(v, m_prev));
    m_prev = v;
    cyc(2);
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL coincide_pop got %h required %h", d, e);
    end
    wb_read(1'b0, ack, d);
    vectors++;
    if (d !== status_exp() || d[7:0] !== 8'd4 || d[31] !== 1'b0) begin
      miscompares++;
      $display("FAIL coincide_status got %h required %h", d, status_exp());
    end
    for (int i = 0; i < 4; i++) begin
      wb_read(1'b1, ack, d);
      e = pop_exp();
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL coincide_drain%0d got %h required %h", i, d, e);
      end
    end
  endtask

  task automatic test_sw_clear();
    logic ack;
    logic [31:0] d, e;
    logic [31:0] req0;
    do_reset();
    do_split(31'h0001_2345, 1'b0);
    do_split(31'h0000_0250, 1'b1);
    // Clear arrives mid-subtraction: this lap keeps the old prev
    i_value = 31'h0003_0000; i_split = 1'b1;
    cyc(1);
    i_split = 1'b0;
    cyc(3);
    i_sw_clear = 1'b1;
    cyc(1);
    i_sw_clear = 1'b0;
    cyc(6);
    model_push(lap_of(31'h0003_0000, m_prev));
    m_prev = '0;
    do_split(31'h0004_1234, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wb_read(1'b1, ack, d);
      e = pop_exp();
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL swclr_lap%0d got %h required %h", i, d, e);
      end
      if (i == 1) req0 = d;
    end
    vectors++;
    if (req0 !== 32'h8000_0250 || d !== 32'h8004_1234) begin
      miscompares++;
      $display("FAIL swclr_fixed got %h,%h required 80000250,80041234", req0, d);
    end
  endtask

  task automatic test_empty_flush();
    logic ack;
    logic [31:0] d, e;
    do_reset();
    wb_read(1'b1, ack, d);
    vectors++;
    if (ack !== 1'b1 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL empty_read got ack=%b %h required 1 00000000", ack, d);
    end
    wb_write(1'b1, 32'hFFFF_FFFF, ack);
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL data_write_ack got %b required 1", ack);
    end
    wb_read(1'b0, ack, d);
    vectors++;
    if (d !== status_exp()) begin
      miscompares++;
      $display("FAIL empty_status got %h required %h", d, status_exp());
    end
    for (int i = 0; i < 3; i++) do_split(rand_bcd(), 1'b0);
    wb_write(1'b0, 32'h2, ack);
    m_q.delete();
    m_prev = '0;
    vectors++;
    if (o_int !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_int_hold got %b required 1", o_int);
    end
    cyc(1);
    vectors++;
    if (o_int !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_int_fall got %b required 0", o_int);
    end
    wb_read(1'b0, ack, d);
    vectors++;
    if (d !== status_exp() || d[7:0] !== 8'd0) begin
      miscompares++;
      $display("FAIL flush_status got %h required %h", d, status_exp());
    end
    do_split(31'h0000_3141, 1'b0);
    wb_read(1'b1, ack, d);
    e = pop_exp();
    vectors++;
    if (d !== e || d !== 32'h8000_3141) begin
      miscompares++;
      $display("FAIL flush_prev got %h required %h", d, e);
    end
  endtask

  task automatic test_reset_mid_sub();
    logic ack;
    logic [31:0] d;
    do_reset();
    do_split(31'h0000_0500, 1'b0);
    i_value = 31'h0000_0900; i_split = 1'b1;
    cyc(1);
    i_split = 1'b0;
    cyc(3);
    i_reset = 1'b1;
    cyc(1);
    i_reset = 1'b0;
    m_q.delete();
    m_prev = '0;
    cyc(15);
    vectors++;
    if (o_int !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_sub_int got %b required 0", o_int);
    end
    wb_read(1'b0, ack, d);
    vectors++;
    if (d !== status_exp()) begin
      miscompares++;
      $display("FAIL rst_sub_status got %h required %h", d, status_exp());
    end
  endtask

  task automatic test_random();
    logic ack;
    logic [31:0] d, e;
    int unsigned r;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(9, 0);
      i_running = 1'($urandom);
      if (r < 4) begin
        do_split(rand_bcd(), 1'($urandom_range(7, 0) == 0));
      end else if (r < 7) begin
        wb_read(1'b1, ack, d);
        e = pop_exp();
        vectors++;
        if (d !== e) begin
          miscompares++;
          $display("FAIL rand_lap it=%0d got %h required %h", i, d, e);
        end
      end else if (r < 9) begin
        wb_read(1'b0, ack, d);
        e = status_exp();
        vectors++;
        if (d !== e) begin
          miscompares++;
          $display("FAIL rand_status it=%0d got %h required %h", i, d, e);
        end
      end else begin
        wb_write(1'b0, 32'h1, ack);
        m_ovf = 1'b0;
        m_missed = 1'b0;
      end
    end
    i_running = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_value = '0; i_running = 1'b0; i_split = 1'b0; i_sw_clear = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_addr = 1'b0; i_wb_data = '0;
    m_prev = '0; m_ovf = 1'b0; m_missed = 1'b0;
    cyc(1);
    test_reset();
    test_basic();
    test_borrow_chain();
    test_missed();
    test_overflow();
    test_sw_clear();
    test_empty_flush();
    test_reset_mid_sub();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
